// File: rtl/ula_arbiter_pkg.sv
// rtl/ula_arbiter_pkg.sv - shared types, constants and winner search for the ULA arbiter
// Contents:
//   state_t     : arbiter FSM states (IDLE, RUN, FIN)
//   N_REQ/IDX_W : requester count and index width
//   LAT_DEFAULT : default ULA occupancy in cycles
//   next_rr()   : first set request bit scanning ptr, ptr+1, ... mod N_REQ
package ula_arb_pkg;

    localparam int N_REQ       = 8;
    localparam int IDX_W       = 3;
    localparam int LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Index arithmetic is done in IDX_W bits so ptr+i wraps 7->0 on its own.
    // An all-zero request vector returns 0; callers only use the result when
    // at least one bit is set.
    function automatic logic [IDX_W-1:0] next_rr(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic             found;
        next_rr = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                next_rr = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/ula_arbiter_if.sv
// rtl/ula_arbiter_if.sv - requester-side bus between the requester blocks and the ULA arbiter
// Signals:
//   E    : arbiter enable (gates new grants only)
//   REQ  : request vector, bit i = requester i
//   SEL  : index of the granted requester, qualified by BUSY
//   GNT  : one-hot grant while the ULA is occupied
//   BUSY : ULA occupied
//   DONE : one-hot single-cycle result-valid pulse
// Modports: master = requester side, slave = arbiter side.
interface ula_arbiter_if;
    import ula_arb_pkg::*;

    logic             E;
    logic [N_REQ-1:0] REQ;
    logic [IDX_W-1:0] SEL;
    logic [N_REQ-1:0] GNT;
    logic             BUSY;
    logic [N_REQ-1:0] DONE;

    modport master (output E, REQ, input SEL, GNT, BUSY, DONE);
    modport slave  (input E, REQ, output SEL, GNT, BUSY, DONE);

endinterface

// File: rtl/ula_arbiter_grant_decoder.sv
// rtl/ula_arbiter_grant_decoder.sv - 3-bit index to gated 8-bit one-hot decoder
// Ports:
//   i_idx    : requester index
//   i_en     : output enable; output is all-zero when low
//   o_onehot : one-hot decode of i_idx
module grant_decoder
    import ula_arb_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_onehot
);

    assign o_onehot = i_en ? (N_REQ'(1) << i_idx) : '0;

endmodule

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - round-robin arbiter/sequencer sharing one ULA between 8 requesters
// Parameters:
//   LAT : ULA occupancy in cycles per operation (1..15)
// Ports:
//   CLK : clock, all state on the rising edge
//   RST : synchronous active-high reset
//   bus : ula_arbiter_if.slave (E, REQ in; SEL, GNT, BUSY, DONE out)
// Build option:
//   ULA_ARB_FIXED_PRIO_EN : lowest-index request always wins; PTR stays 0
module ula_arbiter
    import ula_arb_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    ula_arbiter_if.slave bus
);

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_sel;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] w_winner;
    logic             w_run;
    logic             w_fin;

`ifdef ULA_ARB_FIXED_PRIO_EN
    assign w_winner = next_rr(bus.REQ, '0);
`else
    assign w_winner = next_rr(bus.REQ, r_ptr);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.E && (bus.REQ != '0)) begin
                        r_sel   <= w_winner;
                        r_cnt   <= 4'(LAT - 1);
                        r_state <= ST_RUN;
                    end
                end
                // REQ and E are deliberately not looked at here: an
                // operation, once granted, always runs to completion.
                ST_RUN: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_FIN: begin
`ifndef ULA_ARB_FIXED_PRIO_EN
                    // Served requester drops to lowest priority next round.
                    r_ptr <= r_sel + 3'd1;
`endif
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_run    = (r_state == ST_RUN);
    assign w_fin    = (r_state == ST_FIN);
    assign bus.SEL  = r_sel;
    assign bus.BUSY = w_run;

    grant_decoder u_gnt_dec (
        .i_idx    (r_sel),
        .i_en     (w_run),
        .o_onehot (bus.GNT)
    );

    grant_decoder u_done_dec (
        .i_idx    (r_sel),
        .i_en     (w_fin),
        .o_onehot (bus.DONE)
    );

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - self-checking bench for ula_arbiter (table vectors + grant scoreboard)
module tb_ula_arbiter;

    localparam int LAT = 2;
`ifdef ULA_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    logic [2:0] m_ptr;
    logic [2:0] sb_q[$];

    ula_arbiter_if u_if();

    ula_arbiter #(.LAT(LAT)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         rep;
        logic       e;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic [7:0] done;
    } vec_t;

    vec_t vt[21];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] model_winner(input logic [7:0] req, input logic [2:0] ptr);
        int p;
        p = FIXED ? 0 : int'(ptr);
        for (int k = 0; k < 8; k++) begin
            if (req[(p + k) % 8]) return 3'((p + k) % 8);
        end
        return 3'd0;
    endfunction

    // Pushes the predicted grant sequence, holds REQ, then checks every grant
    // and DONE the DUT produces against the queue, including their spacing.
    task automatic run_sb(input logic [7:0] req, input int n);
        int         last_rise;
        int         dones;
        int         grants;
        int         limit;
        logic [7:0] prev_gnt;
        logic [2:0] cur;
        logic [2:0] w;
        for (int k = 0; k < n; k++) begin
            w = model_winner(req, m_ptr);
            sb_q.push_back(w);
            m_ptr = FIXED ? 3'd0 : w + 3'd1;
        end
        u_if.REQ  = req;
        u_if.E    = 1'b1;
        prev_gnt  = u_if.GNT;
        last_rise = -1;
        dones     = 0;
        grants    = 0;
        cur       = 3'd0;
        limit     = n * (LAT + 2) + 12;
        for (int c = 0; c < limit && dones < n; c++) begin
            tick();
            if (u_if.GNT != 8'h00 && prev_gnt == 8'h00) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra_grant", 32'(u_if.GNT), 32'h0);
                end else begin
                    cur = sb_q.pop_front();
                    chk("sb_gnt", 32'(u_if.GNT), 32'(8'h01 << cur));
                    chk("sb_sel", 32'(u_if.SEL), 32'(cur));
                    chk("sb_busy", 32'(u_if.BUSY), 32'h1);
                    if (last_rise >= 0) chk("sb_spacing", 32'(cyc - last_rise), 32'(LAT + 2));
                    last_rise = cyc;
                    grants++;
                    if (grants == n) u_if.REQ = 8'h00;
                end
            end
            if (u_if.DONE != 8'h00) begin
                chk("sb_done", 32'(u_if.DONE), 32'(8'h01 << cur));
                chk("sb_done_lat", 32'(cyc - last_rise), 32'(LAT));
                chk("sb_done_gnt", 32'(u_if.GNT), 32'h0);
                chk("sb_done_busy", 32'(u_if.BUSY), 32'h0);
                dones++;
            end
            prev_gnt = u_if.GNT;
        end
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        chk("sb_done_count", 32'(dones), 32'(n));
        sb_q.delete();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sb_idle_gnt", 32'(u_if.GNT), 32'h0);
        end
    endtask

    initial begin
        logic [7:0] g17;
        logic [2:0] s17;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        m_ptr  = 3'd0;
        g17    = FIXED ? 8'h01 : 8'h80;
        s17    = FIXED ? 3'd0 : 3'd7;

        //          rep e  req    gnt    sel  busy done
        vt[0]  = '{1,  1, 8'h04, 8'h04, 3'd2, 1, 8'h00};
        vt[1]  = '{1,  1, 8'h04, 8'h04, 3'd2, 1, 8'h00};
        vt[2]  = '{1,  1, 8'h00, 8'h00, 3'd2, 0, 8'h04};
        vt[3]  = '{1,  1, 8'h00, 8'h00, 3'd2, 0, 8'h00};
        vt[4]  = '{10, 0, 8'h01, 8'h00, 3'd2, 0, 8'h00};
        vt[5]  = '{1,  1, 8'h01, 8'h01, 3'd0, 1, 8'h00};
        vt[6]  = '{1,  0, 8'h01, 8'h01, 3'd0, 1, 8'h00};
        vt[7]  = '{1,  0, 8'h01, 8'h00, 3'd0, 0, 8'h01};
        vt[8]  = '{3,  0, 8'h01, 8'h00, 3'd0, 0, 8'h00};
        vt[9]  = '{1,  1, 8'h80, 8'h80, 3'd7, 1, 8'h00};
        vt[10] = '{1,  1, 8'h81, 8'h80, 3'd7, 1, 8'h00};
        vt[11] = '{1,  1, 8'h81, 8'h00, 3'd7, 0, 8'h80};
        vt[12] = '{1,  1, 8'h81, 8'h00, 3'd7, 0, 8'h00};
        vt[13] = '{1,  1, 8'h81, 8'h01, 3'd0, 1, 8'h00};
        vt[14] = '{1,  1, 8'h81, 8'h01, 3'd0, 1, 8'h00};
        vt[15] = '{1,  1, 8'h81, 8'h00, 3'd0, 0, 8'h01};
        vt[16] = '{1,  1, 8'h81, 8'h00, 3'd0, 0, 8'h00};
        vt[17] = '{1,  1, 8'h81, g17,   s17,  1, 8'h00};
        vt[18] = '{1,  1, 8'h00, g17,   s17,  1, 8'h00};
        vt[19] = '{1,  0, 8'h00, 8'h00, s17,  0, g17};
        vt[20] = '{1,  0, 8'h00, 8'h00, s17,  0, 8'h00};

        // Reset state.
        rst      = 1'b1;
        u_if.E   = 1'b0;
        u_if.REQ = 8'h00;
        tick();
        tick();
        chk("rst_gnt", 32'(u_if.GNT), 32'h0);
        chk("rst_sel", 32'(u_if.SEL), 32'h0);
        chk("rst_busy", 32'(u_if.BUSY), 32'h0);
        chk("rst_done", 32'(u_if.DONE), 32'h0);
        rst = 1'b0;

        // Table vectors: inputs applied before the edge, outputs checked after.
        for (int i = 0; i < 21; i++) begin
            for (int r = 0; r < vt[i].rep; r++) begin
                u_if.E   = vt[i].e;
                u_if.REQ = vt[i].req;
                tick();
                chk($sformatf("vec%0d_gnt", i), 32'(u_if.GNT), 32'(vt[i].gnt));
                chk($sformatf("vec%0d_sel", i), 32'(u_if.SEL), 32'(vt[i].sel));
                chk($sformatf("vec%0d_busy", i), 32'(u_if.BUSY), 32'(vt[i].busy));
                chk($sformatf("vec%0d_done", i), 32'(u_if.DONE), 32'(vt[i].done));
            end
        end

        // Reset during the second RUN cycle aborts with no DONE.
        u_if.E   = 1'b1;
        u_if.REQ = 8'hFF;
        tick();
        chk("abort_run1_gnt", 32'(u_if.GNT), 32'h01);
        tick();
        chk("abort_run2_busy", 32'(u_if.BUSY), 32'h1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        u_if.REQ = 8'h00;
        chk("abort_gnt", 32'(u_if.GNT), 32'h0);
        chk("abort_busy", 32'(u_if.BUSY), 32'h0);
        chk("abort_done", 32'(u_if.DONE), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("abort_no_done", 32'(u_if.DONE), 32'h0);
            chk("abort_no_busy", 32'(u_if.BUSY), 32'h0);
        end
        m_ptr = 3'd0;

        // Held requests: full rotation then an upper-half subset.
        run_sb(8'hFF, 9);
        run_sb(8'hF0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
